// File: rtl/sha256_padder.sv
// SHA-256 message padder: forwards message bytes, then appends 0x80, zero
// fill and the 64-bit big-endian bit length so the stream is a multiple of
// 64 bytes. Feeds sha256_processor directly; out_last drives its data_last.
module sha256_padder #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       empty_msg,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS,
        S_PAD80,
        S_ZERO,
        S_LEN,
        S_DONE
    } state_t;

    state_t           state;
    logic [5:0]       pos;
    logic [CNT_W-1:0] cnt;

    logic [63:0] len_bits;
    logic [2:0]  len_sel;
    logic [5:0]  pos_inc;
    logic        out_fire;

    // Bit length = byte count * 8, zero-extended to 64 bits.
    assign len_bits = 64'({cnt, 3'b000});
    // Length bytes occupy pos 56..63; pos[2:0] is the byte index, MSB first.
    assign len_sel  = 3'd7 - pos[2:0];
    assign pos_inc  = pos + 6'd1;
    // In PASS out_valid mirrors in_valid and in_ready mirrors out_ready, so an
    // output transfer there is also the input transfer.
    assign out_fire = out_valid && out_ready;

    // Output decode from registered state/pos/cnt; PASS is a zero-latency
    // pass-through, so its outputs follow the input handshake directly.
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_PASS: begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
            end
            S_PAD80: begin
                out_data  = 8'h80;
                out_valid = 1'b1;
            end
            S_ZERO: begin
                out_valid = 1'b1;
            end
            S_LEN: begin
                out_data  = len_bits[{len_sel, 3'b000} +: 8];
                out_valid = 1'b1;
                out_last  = (pos == 6'd63);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // State machine with the shared byte-position and message-byte counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pos   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pos   <= '0;
                        cnt   <= '0;
                        state <= empty_msg ? S_PAD80 : S_PASS;
                    end
                end
                S_PASS: begin
                    if (out_fire) begin
                        pos <= pos_inc;
                        cnt <= cnt + CNT_W'(1);
                        if (in_last) state <= S_PAD80;
                    end
                end
                S_PAD80, S_ZERO: begin
                    // Zero fill wraps through pos 0 into the next block when
                    // 0x80 landed past byte 55.
                    if (out_fire) begin
                        pos   <= pos_inc;
                        state <= (pos_inc == 6'd56) ? S_LEN : S_ZERO;
                    end
                end
                S_LEN: begin
                    if (out_fire) begin
                        pos <= pos_inc;
                        if (pos == 6'd63) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: "abc", empty, 55/56-byte boundaries,
// stalled/gapped "abc", and asynchronous reset mid-padding.
module tb_sha256_padder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       empty_msg = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [7:0] msg [0:63];
    logic [7:0] got_data [$];
    logic       got_last [$];
    logic [7:0] exp_data [$];
    bit         saw_in_ready;

    sha256_padder #(.CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .empty_msg(empty_msg),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one message; inputs change on negedge, outputs sampled 1ns later.
    // abort_at > 0 stops after that many output transfers (for reset test).
    task automatic run_msg(input int n, input bit stall, input int abort_at);
        int  idx = 0;
        int  cyc = 0;
        bit  finished = 0;
        bit  last_seen = 0;
        bit  fired = 0;
        bit  was_stalled = 0;
        logic [7:0] held_data = '0;
        logic       held_last = 1'b0;
        got_data.delete();
        got_last.delete();
        saw_in_ready = 0;
        @(negedge clk);
        start = 1'b1;
        empty_msg = (n == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        empty_msg = 1'b0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            if (fired) begin
                in_valid = 1'b0;
                in_last = 1'b0;
                fired = 0;
            end
            if (!in_valid && idx < n && (!stall || $urandom_range(0, 2) != 0)) begin
                in_valid = 1'b1;
                in_data = msg[idx];
                in_last = (idx == n - 1);
            end
            out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (in_ready) saw_in_ready = 1;
            if (was_stalled) begin
                check("stall_hold_valid", 64'(out_valid), 64'(1));
                check("stall_hold_data", 64'(out_data), 64'(held_data));
                check("stall_hold_last", 64'(out_last), 64'(held_last));
            end
            was_stalled = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (last_seen) begin
                check("done_pulse", 64'(done), 64'(1));
                finished = 1;
            end else begin
                if (out_valid && out_ready) begin
                    got_data.push_back(out_data);
                    got_last.push_back(out_last);
                    if (out_last) last_seen = 1;
                    if (abort_at > 0 && got_data.size() == abort_at) finished = 1;
                end
                if (in_valid && in_ready) begin
                    idx++;
                    fired = 1;
                end
            end
            cyc++;
        end
        if (!finished) check("timeout", 64'(cyc), 64'(0));
        if (fired || abort_at > 0) begin
            in_valid = 1'b0;
            in_last = 1'b0;
        end
        if (abort_at == 0) begin
            @(negedge clk);
            #1;
            check("done_one_cycle", 64'(done), 64'(0));
            check("idle_after_done", 64'(busy), 64'(0));
        end
    endtask

    // Compares the collected stream to the padding rule for an n-byte message.
    task automatic check_stream(input int n);
        logic [63:0] lbits;
        int          nlast = 0;
        exp_data.delete();
        for (int i = 0; i < n; i++) exp_data.push_back(msg[i]);
        exp_data.push_back(8'h80);
        while ((exp_data.size() % 64) != 56) exp_data.push_back(8'h00);
        lbits = 64'(n) * 64'd8;
        for (int i = 7; i >= 0; i--) exp_data.push_back(lbits[i*8 +: 8]);
        check("stream_len", 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
            check($sformatf("byte_%0d", i), 64'(got_data[i]), 64'(exp_data[i]));
        for (int i = 0; i < got_last.size(); i++) if (got_last[i]) nlast++;
        check("last_count", 64'(nlast), 64'(1));
        if (got_last.size() > 0)
            check("last_on_final", 64'(got_last[got_last.size()-1]), 64'(1));
    endtask

    task automatic load_abc();
        msg[0] = 8'h61;
        msg[1] = 8'h62;
        msg[2] = 8'h63;
    endtask

    initial begin
        #12;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // "abc", no backpressure
        load_abc();
        run_msg(3, 0, 0);
        check_stream(3);
        check("abc_len", 64'(got_data.size()), 64'(64));
        check("abc_b3", 64'(got_data[3]), 64'h80);
        check("abc_b63", 64'(got_data[63]), 64'h18);

        // empty message
        run_msg(0, 0, 0);
        check_stream(0);
        check("empty_b0", 64'(got_data[0]), 64'h80);
        check("empty_len", 64'(got_data.size()), 64'(64));
        check("empty_no_in_ready", 64'(saw_in_ready), 64'(0));

        // 55 bytes: 0x80 at 55, length follows immediately
        for (int i = 0; i < 56; i++) msg[i] = 8'(i + 1);
        run_msg(55, 0, 0);
        check_stream(55);
        check("m55_len", 64'(got_data.size()), 64'(64));
        check("m55_b55", 64'(got_data[55]), 64'h80);
        check("m55_b62", 64'(got_data[62]), 64'h01);
        check("m55_b63", 64'(got_data[63]), 64'hB8);

        // 56 bytes: padding wraps into a second block
        run_msg(56, 0, 0);
        check_stream(56);
        check("m56_len", 64'(got_data.size()), 64'(128));
        check("m56_b56", 64'(got_data[56]), 64'h80);
        check("m56_b126", 64'(got_data[126]), 64'h01);
        check("m56_b127", 64'(got_data[127]), 64'hC0);
        check("m56_no_last_63", 64'(got_last[63]), 64'(0));

        // "abc" with random backpressure and gapped input
        load_abc();
        run_msg(3, 1, 0);
        check_stream(3);
        check("stall_b63", 64'(got_data[63]), 64'h18);

        // 10-byte message, reset during zero fill (10 msg + 0x80 + 3 zeros)
        for (int i = 0; i < 10; i++) msg[i] = 8'(8'hA0 + i);
        run_msg(10, 0, 14);
        @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(busy), 64'(1));
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(0));
        check("arst_out_data", 64'(out_data), 64'(0));
        check("arst_out_last", 64'(out_last), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        load_abc();
        run_msg(3, 0, 0);
        check_stream(3);
        check("post_rst_b63", 64'(got_data[63]), 64'h18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
